fifo_buf: RTL and testbench

- Parametrised synchronous FIFO: pointer/count control plus its own storage array.
- Registered read data, programmable almost-full/almost-empty thresholds, synchronous flush, sticky overflow/underflow error flags.
- Successor to the bare pointer-controller used by maskshare buffering.
- Sits between mask-producing and mask-consuming pipeline stages in the PSU.

---
 rtl/fifo_buf.sv | 92 +++++++++
 tb/tb_fifo_buf.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_buf.sv
// Synchronous FIFO with its own storage and a registered read port: pop at edge N, dout/dout_valid in cycle N+1.
// No backpressure: a push at full or a pop at empty is dropped and latches a sticky error flag until rst/flush.
module fifo_buf #(
    parameter int DATA_BW   = 8,
    parameter int ADDR_BW   = 2,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_din,
    input  logic [DATA_BW-1:0] din,
    input  logic               rd_dout,
    input  logic               flush,
    output logic [DATA_BW-1:0] dout,
    output logic               dout_valid,
    output logic [ADDR_BW:0]   num_item,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               overflow,
    output logic               underflow
);

    localparam int DEPTH = 2 ** ADDR_BW;
    localparam logic [ADDR_BW:0] DEPTH_V  = (ADDR_BW+1)'(DEPTH);
    localparam logic [ADDR_BW:0] AFULL_V  = (ADDR_BW+1)'(AFULL_TH);
    localparam logic [ADDR_BW:0] AEMPTY_V = (ADDR_BW+1)'(AEMPTY_TH);

    logic [DATA_BW-1:0] mem [DEPTH];
    logic [ADDR_BW-1:0] wr_ptr;
    logic [ADDR_BW-1:0] rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    // Status flags depend only on the registered count, never on this cycle's requests.
    assign full         = (num_item == DEPTH_V);
    assign empty        = (num_item == '0);
    assign almost_full  = (num_item >= AFULL_V);
    assign almost_empty = (num_item <= AEMPTY_V);

    assign push_ok = wr_din & ~full & ~flush;
    assign pop_ok  = rd_dout & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            num_item   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            // dout deliberately keeps its last value across a flush.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            num_item   <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_BW'(1);
            end
            if (pop_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + ADDR_BW'(1);
            end
            if (push_ok && !pop_ok) begin
                num_item <= num_item + (ADDR_BW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                num_item <= num_item - (ADDR_BW+1)'(1);
            end
            if (wr_din && full) begin
                overflow <= 1'b1;
            end
            if (rd_dout && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_buf.sv
// Directed bench for fifo_buf at default parameters (DEPTH=4, AFULL_TH=3, AEMPTY_TH=1).
module tb_fifo_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_din = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd_dout = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] num_item;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;

    fifo_buf #(.DATA_BW(8), .ADDR_BW(2), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
        .clk(clk), .rst(rst), .wr_din(wr_din), .din(din), .rd_dout(rd_dout),
        .flush(flush), .dout(dout), .dout_valid(dout_valid), .num_item(num_item),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs for one clock edge, then settle 1 time unit past it before any checks.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
        wr_din  = w;
        din     = d;
        rd_dout = r;
        flush   = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_num", num_item, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_vld", dout_valid, 0);
        chk("rst_dout", dout, 8'h00);

        // Fill and overflow
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        chk("fill1_num", num_item, 1);
        chk("fill1_ae", almost_empty, 1);
        chk("fill1_empty", empty, 0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        chk("fill2_num", num_item, 2);
        chk("fill2_ae", almost_empty, 0);
        chk("fill2_af", almost_full, 0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        chk("fill3_num", num_item, 3);
        chk("fill3_af", almost_full, 1);
        chk("fill3_full", full, 0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        chk("fill4_num", num_item, 4);
        chk("fill4_full", full, 1);
        chk("fill4_ovf", overflow, 0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_num", num_item, 4);
        chk("ovf_set", overflow, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_vld", dout_valid, 0);

        // Drain and underflow
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain1_dout", dout, 8'h11);
        chk("drain1_vld", dout_valid, 1);
        chk("drain1_num", num_item, 3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain2_dout", dout, 8'h22);
        chk("drain2_vld", dout_valid, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain3_dout", dout, 8'h33);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain4_dout", dout, 8'h44);
        chk("drain4_vld", dout_valid, 1);
        chk("drain4_empty", empty, 1);
        chk("drain4_unf", underflow, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", underflow, 1);
        chk("unf_vld", dout_valid, 0);
        chk("unf_dout", dout, 8'h44);
        chk("unf_num", num_item, 0);

        // Clear flags, then simultaneous push+pop at full
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush0_ovf", overflow, 0);
        chk("flush0_unf", underflow, 0);
        chk("flush0_dout", dout, 8'h44);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("refill_full", full, 1);
        cyc(1'b1, 8'h66, 1'b1, 1'b0);
        chk("pp_full_dout", dout, 8'h01);
        chk("pp_full_vld", dout_valid, 1);
        chk("pp_full_num", num_item, 3);
        chk("pp_full_ovf", overflow, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pp_rest1", dout, 8'h02);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pp_rest2", dout, 8'h03);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pp_rest3", dout, 8'h04);
        chk("pp_rest3_empty", empty, 1);
        chk("pp_rest3_unf", underflow, 0);

        // Simultaneous push+pop at empty
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("pp_empty_num", num_item, 1);
        chk("pp_empty_vld", dout_valid, 0);
        chk("pp_empty_dout", dout, 8'h04);
        chk("pp_empty_unf", underflow, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pp_empty_pop", dout, 8'h77);
        chk("pp_empty_pop_num", num_item, 0);

        // Wrap-around at occupancy 2
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        chk("wrap_pre_num", num_item, 2);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 8'(k + 2), 1'b1, 1'b0);
            chk($sformatf("wrap%0d_dout", k), dout, 32'(k));
            chk($sformatf("wrap%0d_vld", k), dout_valid, 1);
            chk($sformatf("wrap%0d_num", k), num_item, 2);
        end

        // Flush mid-operation at occupancy 3 with overflow still set
        cyc(1'b1, 8'h0C, 1'b0, 1'b0);
        chk("preflush_num", num_item, 3);
        chk("preflush_ovf", overflow, 1);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("flush_num", num_item, 0);
        chk("flush_empty", empty, 1);
        chk("flush_ovf", overflow, 0);
        chk("flush_unf", underflow, 0);
        chk("flush_vld", dout_valid, 0);
        chk("flush_dout", dout, 8'h09);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("postflush_num", num_item, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("postflush_dout", dout, 8'hA5);
        chk("postflush_vld", dout_valid, 1);

        // Reset mid-operation with push and flush asserted
        cyc(1'b1, 8'hB1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0);
        chk("prerst_num", num_item, 2);
        rst = 1'b1;
        cyc(1'b1, 8'hB3, 1'b0, 1'b1);
        rst = 1'b0;
        chk("midrst_num", num_item, 0);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_empty", empty, 1);
        chk("midrst_vld", dout_valid, 0);
        chk("midrst_ovf", overflow, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("postrst_vld", dout_valid, 0);
        chk("postrst_dout", dout, 8'h00);
        chk("postrst_unf", underflow, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
